// File: rtl/risc_v_alu_issue.sv
// Decode-to-execute issue stage for risc_v_alu: decodes an RV32I word, picks operand B
// and holds the result in a one-entry ID/EX register with valid/ready, stall and flush.
module risc_v_alu_issue #(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [2:0]  ex_alu_control,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_branch_ne,
  output logic        ex_of_en,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic        w_legal;
  logic [2:0]  w_code;
  logic        w_use_imm;
  logic [31:0] w_imm;
  logic [31:0] w_b;
  logic [4:0]  w_rd;
  logic        w_rw;
  logic        w_mr;
  logic        w_mw;
  logic        w_br;
  logic        w_bne;
  logic        w_of;
  logic        w_load;
  logic        w_issue;

  logic        r_valid;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_code;
  logic [4:0]  r_rd;
  logic        r_rw;
  logic        r_mr;
  logic        r_mw;
  logic        r_br;
  logic        r_bne;
  logic        r_of;
  logic [31:0] r_sd;
  logic        r_ill;

  assign w_opcode = id_instr[6:0];
  assign w_f3     = id_instr[14:12];
  assign w_f7     = id_instr[31:25];
  assign w_imm_i  = {{20{id_instr[31]}}, id_instr[31:20]};
  assign w_imm_s  = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};

  // Enables and rd are only raised inside legal arms, so illegal words decode to all-zero.
  always_comb begin
    w_legal   = 1'b0;
    w_code    = ALU_ADD;
    w_use_imm = 1'b0;
    w_imm     = w_imm_i;
    w_rd      = 5'd0;
    w_rw      = 1'b0;
    w_mr      = 1'b0;
    w_mw      = 1'b0;
    w_br      = 1'b0;
    w_bne     = 1'b0;
    w_of      = 1'b0;
    case (w_opcode)
      OP_R: begin
        case (w_f3)
          3'b000: begin
            if (w_f7 == 7'b0000000) begin
              w_legal = 1'b1;
              w_code  = ALU_ADD;
            end else if (w_f7 == 7'b0100000) begin
              w_legal = 1'b1;
              w_code  = ALU_SUB;
            end
            w_of = w_legal;
          end
          3'b111: begin w_legal = (w_f7 == 7'b0); w_code = ALU_AND; end
          3'b110: begin w_legal = (w_f7 == 7'b0); w_code = ALU_OR;  end
          3'b010: begin w_legal = (w_f7 == 7'b0); w_code = ALU_SLT; end
          default: w_legal = 1'b0;
        endcase
        if (!w_legal) w_code = ALU_ADD;
        w_rw = w_legal;
        w_rd = w_legal ? id_instr[11:7] : 5'd0;
      end
      OP_I: begin
        w_legal = 1'b1;
        case (w_f3)
          3'b000:  begin w_code = ALU_ADD; w_of = 1'b1; end
          3'b111:  w_code = ALU_AND;
          3'b110:  w_code = ALU_OR;
          3'b010:  w_code = ALU_SLT;
          default: w_legal = 1'b0;
        endcase
        if (w_legal) begin
          w_use_imm = 1'b1;
          w_rw      = 1'b1;
          w_rd      = id_instr[11:7];
        end
      end
      OP_LOAD: begin
        if (w_f3 == 3'b010) begin
          w_legal   = 1'b1;
          w_use_imm = 1'b1;
          w_mr      = 1'b1;
          w_rw      = 1'b1;
          w_rd      = id_instr[11:7];
        end
      end
      OP_STORE: begin
        if (w_f3 == 3'b010) begin
          w_legal   = 1'b1;
          w_use_imm = 1'b1;
          w_imm     = w_imm_s;
          w_mw      = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (w_f3[2:1] == 2'b00) begin
          w_legal = 1'b1;
          w_code  = ALU_SUB;
          w_br    = 1'b1;
          w_bne   = w_f3[0];
        end
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_b      = w_use_imm ? w_imm : id_rs2_data;
  assign id_ready = ~r_valid | ex_ready;
  assign w_load   = id_valid & id_ready & ~flush;
  // Dropped illegals still complete the handshake; they just never become valid.
  assign w_issue  = ILLEGAL_TRAP | w_legal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_code  <= '0;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_mr    <= 1'b0;
      r_mw    <= 1'b0;
      r_br    <= 1'b0;
      r_bne   <= 1'b0;
      r_of    <= 1'b0;
      r_sd    <= '0;
      r_ill   <= 1'b0;
    end else begin
      if (flush)        r_valid <= 1'b0;
      else if (w_load)  r_valid <= w_issue;
      else if (ex_ready) r_valid <= 1'b0;
      if (w_load) begin
        r_a    <= id_rs1_data;
        r_b    <= w_b;
        r_code <= w_code;
        r_rd   <= w_rd;
        r_rw   <= w_rw;
        r_mr   <= w_mr;
        r_mw   <= w_mw;
        r_br   <= w_br;
        r_bne  <= w_bne;
        r_of   <= w_of;
        r_sd   <= id_rs2_data;
        r_ill  <= ~w_legal;
      end
    end
  end

  assign ex_valid       = r_valid;
  assign ex_a           = r_a;
  assign ex_b           = r_b;
  assign ex_alu_control = r_code;
  assign ex_rd          = r_rd;
  assign ex_reg_write   = r_rw;
  assign ex_mem_read    = r_mr;
  assign ex_mem_write   = r_mw;
  assign ex_branch      = r_br;
  assign ex_branch_ne   = r_bne;
  assign ex_of_en       = r_of;
  assign ex_store_data  = r_sd;
  assign ex_illegal     = r_ill;

endmodule

// File: tb/tb_risc_v_alu_issue.sv
// Bench for risc_v_alu_issue: one trapping and one dropping instance share the inputs;
// expected entries are queued on handshake and popped when the execute side consumes.
module tb_risc_v_alu_issue;

  localparam int W = 111;
  localparam logic [6:0] F_RW  = 7'b0000001;
  localparam logic [6:0] F_MR  = 7'b0000010;
  localparam logic [6:0] F_MW  = 7'b0000100;
  localparam logic [6:0] F_BR  = 7'b0001000;
  localparam logic [6:0] F_BNE = 7'b0010000;
  localparam logic [6:0] F_OF  = 7'b0100000;
  localparam logic [6:0] F_ILL = 7'b1000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        flush;
  logic        ex_ready;

  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_branch_ne, ex_of_en, ex_illegal;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [2:0]  ex_alu_control;
  logic [4:0]  ex_rd;

  logic        d_id_ready, d_ex_valid, d_reg_write, d_mem_read, d_mem_write;
  logic        d_branch, d_branch_ne, d_of_en, d_illegal;
  logic [31:0] d_a, d_b, d_store_data;
  logic [2:0]  d_alu_control;
  logic [4:0]  d_rd;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] drv_exp;
  logic [W-1:0] obs;
  int n_checks = 0;
  int n_fail   = 0;

  risc_v_alu_issue #(.ILLEGAL_TRAP(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_control(ex_alu_control), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_branch_ne(ex_branch_ne), .ex_of_en(ex_of_en), .ex_store_data(ex_store_data),
    .ex_illegal(ex_illegal)
  );

  risc_v_alu_issue #(.ILLEGAL_TRAP(1'b0)) u_drop (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(d_id_ready),
    .id_instr(id_instr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(d_ex_valid), .ex_a(d_a), .ex_b(d_b),
    .ex_alu_control(d_alu_control), .ex_rd(d_rd), .ex_reg_write(d_reg_write),
    .ex_mem_read(d_mem_read), .ex_mem_write(d_mem_write), .ex_branch(d_branch),
    .ex_branch_ne(d_branch_ne), .ex_of_en(d_of_en), .ex_store_data(d_store_data),
    .ex_illegal(d_illegal)
  );

  // Clock / reset-independent infrastructure
  always #5 clk = ~clk;

  assign obs = {ex_illegal, ex_of_en, ex_branch_ne, ex_branch, ex_mem_write, ex_mem_read,
                ex_reg_write, ex_rd, ex_alu_control, ex_store_data, ex_b, ex_a};

  function automatic logic [W-1:0] mk(input logic [31:0] a, b, sd, input logic [2:0] code,
                                      input logic [4:0] rd, input logic [6:0] fl);
    return {fl, rd, code, sd, b, a};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: pop/compare on consume, kill on flush, push on accepted input.
  always @(negedge clk) begin
    if (reset_n) begin
      if (flush) begin
        if (ex_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_issue", {17'd0, obs}, 128'd0);
        end else begin
          logic [W-1:0] e;
          logic [W-1:0] o;
          e = exp_q.pop_front();
          o = obs;
          if (e[W-1]) begin
            e[63:0] = '0;
            o[63:0] = '0;
          end
          check_eq("sb_entry", {17'd0, o}, {17'd0, e});
        end
      end
      if (id_valid && id_ready && !flush) exp_q.push_back(drv_exp);
    end
  end

  // Driver tasks
  task automatic step(input logic [31:0] instr, rs1, rs2, input logic v, rdy, fl,
                      input logic [W-1:0] e);
    id_instr    = instr;
    id_rs1_data = rs1;
    id_rs2_data = rs2;
    id_valid    = v;
    ex_ready    = rdy;
    flush       = fl;
    drv_exp     = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [2:0] code, input logic [4:0] rd,
                       input logic [6:0] fl, input bit use_imm, input logic [31:0] imm);
    logic [31:0] r1;
    logic [31:0] r2;
    r1 = $urandom;
    r2 = $urandom;
    step(instr, r1, r2, 1'b1, 1'b1, 1'b0, mk(r1, use_imm ? imm : r2, r2, code, rd, fl));
    check_eq("issue_valid", {127'd0, ex_valid}, 128'd1);
    check_eq("drop_valid", {127'd0, d_ex_valid}, {127'd0, ~fl[6]});
    check_eq("drop_id_ready", {127'd0, d_id_ready}, 128'd1);
  endtask

  initial begin
    logic [W-1:0] saved;
    reset_n = 1'b0;
    step(32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, '0);
    step(32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, '0);
    check_eq("rst_ex_valid", {127'd0, ex_valid}, 128'd0);
    check_eq("rst_outputs", {17'd0, obs}, 128'd0);
    check_eq("rst_id_ready", {127'd0, id_ready}, 128'd1);
    check_eq("rst_drop_valid", {127'd0, d_ex_valid}, 128'd0);
    reset_n  = 1'b1;
    id_valid = 1'b0;

    step(32'h002081B3, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0, mk(5, 7, 7, 3'b000, 5'd3, F_RW | F_OF));
    check_eq("first_valid", {127'd0, ex_valid}, 128'd1);
    check_eq("first_entry", {17'd0, obs}, {17'd0, mk(5, 7, 7, 3'b000, 5'd3, F_RW | F_OF)});

    // Decode sweep, back to back
    issue(32'h402081B3, 3'b001, 5'd3, F_RW | F_OF, 0, 0);          // sub
    issue(32'h0020F1B3, 3'b010, 5'd3, F_RW, 0, 0);                 // and
    issue(32'h0020E1B3, 3'b011, 5'd3, F_RW, 0, 0);                 // or
    issue(32'h0020A1B3, 3'b101, 5'd3, F_RW, 0, 0);                 // slt
    issue(32'hFFF00093, 3'b000, 5'd1, F_RW | F_OF, 1, 32'hFFFFFFFF); // addi x1,x0,-1
    issue(32'hFF00F213, 3'b010, 5'd4, F_RW, 1, 32'hFFFFFFF0);       // andi x4,x1,-16
    issue(32'h0010A213, 3'b101, 5'd4, F_RW, 1, 32'h00000001);       // slti x4,x1,1
    issue(32'h0080A283, 3'b000, 5'd5, F_MR | F_RW, 1, 32'h00000008); // lw x5,8(x1)
    issue(32'hFE20AE23, 3'b000, 5'd0, F_MW, 1, 32'hFFFFFFFC);       // sw x2,-4(x1)
    issue(32'h00209463, 3'b001, 5'd0, F_BR | F_BNE, 0, 0);          // bne x1,x2
    issue(32'h00208063, 3'b001, 5'd0, F_BR, 0, 0);                  // beq x1,x2
    issue(32'h0000007F, 3'b000, 5'd0, F_ILL, 0, 0);                 // unknown opcode
    check_eq("ill_flag", {127'd0, ex_illegal}, 128'd1);
    issue(32'h4020F1B3, 3'b000, 5'd0, F_ILL, 0, 0);                 // and with funct7[5]
    issue(32'h00008283, 3'b000, 5'd0, F_ILL, 0, 0);                 // lb
    issue(32'h0020C063, 3'b000, 5'd0, F_ILL, 0, 0);                 // blt
    issue(32'h002081B3, 3'b000, 5'd3, F_RW | F_OF, 0, 0);           // legal after illegal
    idle();

    // Stall: entry holds while ex_ready is low and the input keeps changing
    step(32'h002081B3, 32'd11, 32'd22, 1'b1, 1'b0, 1'b0, mk(11, 22, 22, 3'b000, 5'd3, F_RW | F_OF));
    saved = obs;
    for (int i = 0; i < 3; i++) begin
      step($urandom, $urandom, $urandom, 1'b1, 1'b0, 1'b0, '1);
      check_eq("stall_id_ready", {127'd0, id_ready}, 128'd0);
      check_eq("stall_hold", {17'd0, obs}, {17'd0, saved});
    end
    step(32'h0020E1B3, 32'd33, 32'd44, 1'b1, 1'b1, 1'b0, mk(33, 44, 44, 3'b011, 5'd3, F_RW));
    check_eq("no_bubble_valid", {127'd0, ex_valid}, 128'd1);
    check_eq("no_bubble_entry", {17'd0, obs}, {17'd0, mk(33, 44, 44, 3'b011, 5'd3, F_RW)});
    idle();
    check_eq("drained_valid", {127'd0, ex_valid}, 128'd0);

    // Flush kills the held entry and the concurrent input
    step(32'h002081B3, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, mk(1, 2, 2, 3'b000, 5'd3, F_RW | F_OF));
    step(32'h402081B3, 32'd3, 32'd4, 1'b1, 1'b0, 1'b1, '1);
    check_eq("flush_valid", {127'd0, ex_valid}, 128'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq("post_flush_valid", {127'd0, ex_valid}, 128'd0);
    end

    // Asynchronous reset during a stall
    step(32'h0020F1B3, 32'd9, 32'd8, 1'b1, 1'b0, 1'b0, mk(9, 8, 8, 3'b010, 5'd3, F_RW));
    id_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    check_eq("async_rst_valid", {127'd0, ex_valid}, 128'd0);
    check_eq("async_rst_outputs", {17'd0, obs}, 128'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    issue(32'h0020A1B3, 3'b101, 5'd3, F_RW, 0, 0);
    idle();
    idle();

    check_eq("sb_drain", {96'd0, 32'(exp_q.size())}, 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/risc_v_alu_issue.md
# risc_v_alu_issue

Decode-to-execute issue stage that produces the operands and the 3-bit ALU control code for `risc_v_alu`. It is the producing end of that ALU's interface. It accepts a decoded RV32I instruction word with its register-file read data. It decodes the word, selects operand B (rs2 or a sign-extended immediate), and registers everything into a one-entry ID/EX pipeline register with a valid/ready handshake, flush and stall support.

## Interface
Parameters:
- `ILLEGAL_TRAP`, default 1: 1 = unsupported instructions are issued with `ex_illegal`=1; 0 = they are silently dropped (accepted, never issued).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: instruction and operands on `id_*` are valid.
- `id_ready` out 1: stage can accept this cycle.
- `id_instr` in 32: instruction word.
- `id_rs1_data` in 32: register rs1 read data.
- `id_rs2_data` in 32: register rs2 read data.
- `flush` in 1: synchronous kill of the held entry and the current input.
- `ex_ready` in 1: execute stage consumes the entry this cycle.
- `ex_valid` out 1: entry valid.
- `ex_a` out 32: ALU operand A (= rs1 data).
- `ex_b` out 32: ALU operand B (rs2 data or immediate).
- `ex_alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ex_rd` out 5: destination register.
- `ex_reg_write` out 1: write-back enable.
- `ex_mem_read` out 1: load.
- `ex_mem_write` out 1: store.
- `ex_branch` out 1: beq/bne.
- `ex_branch_ne` out 1: 1 = bne.
- `ex_of_en` out 1: ALU OF flag is meaningful (add/sub of R/I arithmetic only).
- `ex_store_data` out 32: rs2 data for stores.
- `ex_illegal` out 1: unsupported encoding.

## Operation
- Opcode decode:
  - 0110011 (R): funct3 000 is add, or sub when funct7[5]=1. 111 and, 110 or, 010 slt. `ex_b`=rs2, reg_write=1.
  - 0010011 (I-ALU): funct3 000 addi, 111 andi, 110 ori, 010 slti. `ex_b`=immI, reg_write=1.
  - 0000011 load, funct3 010 only: add, `ex_b`=immI, mem_read=1, reg_write=1.
  - 0100011 store, funct3 010 only: add, `ex_b`=immS, mem_write=1, rd forced 0.
  - 1100011 branch, funct3 000/001: sub, `ex_b`=rs2, branch=1, branch_ne=funct3[0], rd forced 0.
- Anything else is illegal. Its outputs are ALU code 000, all enables 0, rd 0, `ex_illegal`=1 (if `ILLEGAL_TRAP`=1).
- For R-type, any funct7 other than 0000000, or 0100000 with funct3=000, is illegal.
- Immediates are sign-extended from instr[31]:
  - immI = instr[31:20].
  - immS = {instr[31:25], instr[11:7]}.
- `ex_of_en`=1 only for R add/sub and addi.

## Timing
- Reset (`reset_n`=0, asynchronous): every output register is 0, so `ex_valid`=0, all data/control outputs 0, and `id_ready`=1 after reset.
- `id_ready` = ~`ex_valid` | `ex_ready`. It is combinational and independent of `id_valid`.
- Load: the entry is written at the rising edge where `id_valid & id_ready & ~flush`. Latency is 1 cycle from input to `ex_*`.
- Hold: while `ex_valid` & ~`ex_ready`, all `ex_*` outputs stay stable (stall).
- Consume without new input: `ex_valid` goes to 0 on the next edge. Data registers may hold stale values.
- Simultaneous consume and load: the new entry replaces the old with no bubble, giving full throughput of one instruction per cycle.
- `flush`=1: the next edge clears `ex_valid` and discards any concurrent input. `flush` has priority over load and hold.
- Illegal with `ILLEGAL_TRAP`=0: the instruction is accepted (handshake completes) but `ex_valid` is 0 the following cycle.
- `reset_n` asserted mid-stall: the entry is lost immediately and outputs go to 0 asynchronously.

## Test plan
- **Reset.** Hold `reset_n`=0 with `id_valid`=1. Required: `ex_valid`=0, all outputs 0, `id_ready`=1. Release, then feed add x3,x1,x2 (0x002081B3) with rs1=5, rs2=7. Required next cycle: ex_a=5, ex_b=7, code 000, rd=3, reg_write=1, of_en=1.
- **Decode sweep.** Feed each of the following and check the result one cycle later:
  - sub (0x402081B3): code 001.
  - and: code 010.
  - or: code 011.
  - slt: code 101.
  - addi x1,x0,-1 (0xFFF00093): ex_b=0xFFFFFFFF.
  - sw x2,-4(x1) (0xFE20AE23): ex_b=0xFFFFFFFC, mem_write=1, store_data=rs2, rd=0.
- **Branch.** bne x1,x2 (0x00209463). Required: code 001, branch=1, branch_ne=1, reg_write=0.
- **Stall.** Load an entry, hold `ex_ready`=0 for 3 cycles while the input changes. Required: `id_ready`=0 and the outputs unchanged. Then `ex_ready`=1 with a new valid input. Required: the new entry appears next cycle with no bubble.
- **Flush.** With `ex_valid`=1, assert `flush` and `id_valid` together. Required: `ex_valid`=0 next cycle, and the input is not issued afterwards.
- **Illegal.** Feed 0x0000007F.
  - `ILLEGAL_TRAP`=1: required `ex_valid`=1, `ex_illegal`=1, code 000, all enables 0.
  - `ILLEGAL_TRAP`=0: required `ex_valid` stays 0 and `id_ready` stays 1.
